// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction prefetch path.
package riscv_fetch_pkg;

    localparam int XLEN       = 32;
    localparam int INSN_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // One prefetched word, tagged by its word address.
    typedef struct packed {
        logic [XLEN-3:0] addr;
        logic [XLEN-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO with a one-cycle clear; head is visible combinationally.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 62
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_data,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [W-1:0]           o_head
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && (r_count != (PW+1)'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetcher between hart and I-cache.
// Optional PREFETCH_STATS_EN adds hit_count / redirect_count outputs.
module fetch_prefetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cpu_addr_valid,
    input  logic [XLEN-1:0] cpu_addr,
    output logic            cpu_data_ready,
    output logic [XLEN-1:0] cpu_data_o,
    output logic            mem_addr_valid,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_data_ready,
    input  logic [XLEN-1:0] mem_data_i
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     redirect_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    r_state;
    fetch_state_t    w_next;
    logic [XLEN-1:0] r_fetch_addr;
    logic [XLEN-1:0] r_mem_addr;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occ;
    fifo_entry_t     w_head;
    fifo_entry_t     w_push_entry;
    logic            w_empty;
    logic            w_hit;
    logic            w_pend;
    logic            w_redirect;
    logic            w_push;
    logic            w_unused_ok;

    assign w_empty    = (w_count == '0);
    assign w_hit      = cpu_addr_valid && !w_empty && (r_state != FLUSH)
                        && (cpu_addr[XLEN-1:2] == w_head.addr);
    // Requested word is in flight or next in line: wait rather than restart.
    assign w_pend     = w_empty && (cpu_addr[XLEN-1:2] == r_fetch_addr[XLEN-1:2]);
    assign w_redirect = cpu_addr_valid && !w_hit && !w_pend;
    assign w_push     = (r_state == FETCH) && mem_data_ready && !w_redirect;
    assign w_occ      = {1'b0, w_count} + {{CW{1'b0}}, w_hit};

    assign w_push_entry.addr = r_mem_addr[XLEN-1:2];
    assign w_push_entry.data = mem_data_i;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fifo_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_redirect),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_hit),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fetch_addr <= {RESET_PC[XLEN-1:2], 2'b00};
            r_mem_addr   <= RESET_PC;
        end else begin
            r_state <= w_next;
            if (w_redirect)  r_fetch_addr <= {cpu_addr[XLEN-1:2], 2'b00};
            else if (w_push) r_fetch_addr <= r_fetch_addr + XLEN'(INSN_BYTES);
            if (r_state == IDLE && w_next == FETCH) r_mem_addr <= r_fetch_addr;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!w_redirect && (w_occ < (CW+1)'(DEPTH))) w_next = FETCH;
            // A redirect landing with the reply drops the word; nothing is left to flush.
            FETCH:   if (w_redirect)          w_next = mem_data_ready ? IDLE : FLUSH;
                     else if (mem_data_ready) w_next = IDLE;
            FLUSH:   if (mem_data_ready)      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_valid = (r_state != IDLE);
        mem_addr       = r_mem_addr;
        cpu_data_ready = w_hit;
        cpu_data_o     = w_empty ? '0 : w_head.data;
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count      <= '0;
            redirect_count <= '0;
        end else begin
            if (w_hit)      hit_count      <= hit_count + 32'd1;
            if (w_redirect) redirect_count <= redirect_count + 32'd1;
        end
    end
`endif

    assign w_unused_ok = ^{cpu_addr[1:0]};

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed self-checking bench for fetch_prefetch_buffer (DEPTH=4, RESET_PC=0).
module tb_fetch_prefetch_buffer;

    logic        clk;
    logic        rst;
    logic        cpu_addr_valid;
    logic [31:0] cpu_addr;
    logic        cpu_data_ready;
    logic [31:0] cpu_data_o;
    logic        mem_addr_valid;
    logic [31:0] mem_addr;
    logic        mem_data_ready;
    logic [31:0] mem_data_i;
`ifdef PREFETCH_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] redirect_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_prefetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_addr_valid (cpu_addr_valid),
        .cpu_addr       (cpu_addr),
        .cpu_data_ready (cpu_data_ready),
        .cpu_data_o     (cpu_data_o),
        .mem_addr_valid (mem_addr_valid),
        .mem_addr       (mem_addr),
        .mem_data_ready (mem_data_ready),
        .mem_data_i     (mem_data_i)
`ifdef PREFETCH_STATS_EN
        ,
        .hit_count      (hit_count),
        .redirect_count (redirect_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait for a request, check its address, answer one cycle later.
    task automatic serve(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        while (!mem_addr_valid && n < 20) begin
            tick();
            n++;
        end
        chk("serve_valid", {31'd0, mem_addr_valid}, 32'd1);
        chk("serve_addr", mem_addr, a);
        tick();
        mem_data_ready = 1'b1;
        mem_data_i     = d;
        #1;
        tick();
        mem_data_ready = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cpu_addr_valid = 1'b0; cpu_addr = '0;
        mem_data_ready = 1'b0; mem_data_i = '0;
        tick(); tick();
        chk("rst_mem_valid", {31'd0, mem_addr_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_ready", {31'd0, cpu_data_ready}, 32'd0);
        chk("rst_cpu_data", cpu_data_o, 32'h0);
        rst = 1'b0;

        // Hart stalled: exactly four requests fill the FIFO.
        serve(32'h0000_0000, 32'hC0DE_0000);
        serve(32'h0000_0004, 32'hC0DE_0004);
        serve(32'h0000_0008, 32'hC0DE_0008);
        serve(32'h0000_000C, 32'hC0DE_000C);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_no_req", {31'd0, mem_addr_valid}, 32'd0);
        end

        // Sequential hits, zero latency.
        cpu_addr_valid = 1'b1; cpu_addr = 32'h0; #1;
        chk("hit0_rdy", {31'd0, cpu_data_ready}, 32'd1);
        chk("hit0_data", cpu_data_o, 32'hC0DE_0000);
        tick(); cpu_addr = 32'h4; #1;
        chk("hit4_rdy", {31'd0, cpu_data_ready}, 32'd1);
        chk("hit4_data", cpu_data_o, 32'hC0DE_0004);
        tick(); cpu_addr = 32'h8; #1;
        chk("hit8_rdy", {31'd0, cpu_data_ready}, 32'd1);
        chk("hit8_data", cpu_data_o, 32'hC0DE_0008);
        tick(); cpu_addr = 32'hC; #1;
        chk("hitC_rdy", {31'd0, cpu_data_ready}, 32'd1);
        chk("hitC_data", cpu_data_o, 32'hC0DE_000C);
        chk("refill_valid", {31'd0, mem_addr_valid}, 32'd1);
        chk("refill_addr", mem_addr, 32'h10);
        tick(); cpu_addr_valid = 1'b0;

        // Fill 0x10-0x1C, then redirect to 0x100.
        serve(32'h0000_0010, 32'hC0DE_0010);
        serve(32'h0000_0014, 32'hC0DE_0014);
        serve(32'h0000_0018, 32'hC0DE_0018);
        serve(32'h0000_001C, 32'hC0DE_001C);
        tick();
        chk("full2_no_req", {31'd0, mem_addr_valid}, 32'd0);
        cpu_addr_valid = 1'b1; cpu_addr = 32'h100; #1;
        chk("redir_no_hit", {31'd0, cpu_data_ready}, 32'd0);
        chk("redir_head_data", cpu_data_o, 32'hC0DE_0010);
        tick();
        chk("redir_cleared", cpu_data_o, 32'h0);
        chk("redir_idle", {31'd0, mem_addr_valid}, 32'd0);
        tick();
        chk("redir_req_valid", {31'd0, mem_addr_valid}, 32'd1);
        chk("redir_req_addr", mem_addr, 32'h100);
        chk("redir_wait", {31'd0, cpu_data_ready}, 32'd0);
        tick(); mem_data_ready = 1'b1; mem_data_i = 32'hE000_0100; #1;
        chk("miss_same_cycle", {31'd0, cpu_data_ready}, 32'd0);
        tick(); mem_data_ready = 1'b0; #1;
        chk("miss_next_rdy", {31'd0, cpu_data_ready}, 32'd1);
        chk("miss_next_data", cpu_data_o, 32'hE000_0100);

        // Now FETCH 0x104: redirect to 0x40 goes through FLUSH.
        tick(); cpu_addr = 32'h40; #1;
        chk("pf104_addr", mem_addr, 32'h104);
        chk("pf104_no_hit", {31'd0, cpu_data_ready}, 32'd0);
        tick(); cpu_addr_valid = 1'b0; mem_data_ready = 1'b1; mem_data_i = 32'hBAD0_0104; #1;
        chk("flush_valid", {31'd0, mem_addr_valid}, 32'd1);
        chk("flush_addr_held", mem_addr, 32'h104);
        tick(); mem_data_ready = 1'b0; #1;
        chk("flush_done_idle", {31'd0, mem_addr_valid}, 32'd0);
        tick();
        chk("req40_addr", mem_addr, 32'h40);
        chk("req40_valid", {31'd0, mem_addr_valid}, 32'd1);

        // Redirect to 0x200 while 0x40 is pending.
        cpu_addr_valid = 1'b1; cpu_addr = 32'h200; #1;
        chk("r200_no_hit", {31'd0, cpu_data_ready}, 32'd0);
        tick(); mem_data_ready = 1'b1; mem_data_i = 32'hBAD0_0040; #1;
        chk("flush40_addr", mem_addr, 32'h40);
        chk("flush40_rdy", {31'd0, cpu_data_ready}, 32'd0);
        tick(); mem_data_ready = 1'b0; #1;
        chk("drop40_idle", {31'd0, mem_addr_valid}, 32'd0);
        chk("drop40_rdy", {31'd0, cpu_data_ready}, 32'd0);
        chk("drop40_data", cpu_data_o, 32'h0);
        tick();
        chk("req200_addr", mem_addr, 32'h200);
        tick(); mem_data_ready = 1'b1; mem_data_i = 32'hC000_0200; #1;
        tick(); mem_data_ready = 1'b0; #1;
        chk("hit200_rdy", {31'd0, cpu_data_ready}, 32'd1);
        chk("hit200_data", cpu_data_o, 32'hC000_0200);

        // FETCH 0x204: redirect with the reply in the same cycle drops it and skips FLUSH.
        tick(); cpu_addr = 32'hFFFF_FFFC; mem_data_ready = 1'b1; mem_data_i = 32'hDEAD_0204; #1;
        chk("pf204_addr", mem_addr, 32'h204);
        chk("pf204_no_hit", {31'd0, cpu_data_ready}, 32'd0);
        tick(); mem_data_ready = 1'b0; #1;
        chk("race_idle", {31'd0, mem_addr_valid}, 32'd0);
        chk("race_dropped", cpu_data_o, 32'h0);
        tick();
        chk("reqtop_addr", mem_addr, 32'hFFFF_FFFC);
        tick(); mem_data_ready = 1'b1; mem_data_i = 32'hF000_FFFC; #1;
        tick(); mem_data_ready = 1'b0; #1;
        chk("hittop_rdy", {31'd0, cpu_data_ready}, 32'd1);
        chk("hittop_data", cpu_data_o, 32'hF000_FFFC);
        tick(); cpu_addr_valid = 1'b0; #1;
        chk("wrap_valid", {31'd0, mem_addr_valid}, 32'd1);
        chk("wrap_addr", mem_addr, 32'h0);

        // Reset mid-fetch with a reply on the same edge.
        tick(); mem_data_ready = 1'b1; mem_data_i = 32'h1111_0000; #1;
        tick(); mem_data_ready = 1'b0; #1;
        tick();
        chk("pre_rst_addr", mem_addr, 32'h4);
        rst = 1'b1; mem_data_ready = 1'b1; mem_data_i = 32'h2222_0004; #1;
        tick(); rst = 1'b0; mem_data_ready = 1'b0; #1;
        chk("midrst_valid", {31'd0, mem_addr_valid}, 32'd0);
        chk("midrst_addr", mem_addr, 32'h0);
        chk("midrst_empty", cpu_data_o, 32'h0);
        cpu_addr_valid = 1'b1; cpu_addr = 32'h4; #1;
        chk("midrst_no_hit", {31'd0, cpu_data_ready}, 32'd0);
        cpu_addr_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
